// File: rtl/my_cpu_pkg.sv
// my_cpu_pkg: shared constants, FSM encoding and fetch-entry sizing for the MY_CPU fetch stage
package my_cpu_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RESET_PC = 0;
  localparam int DEF_ENTRY_W = DEF_DATA_W + DEF_ADDR_W;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fetch_state_e;
  function automatic int entry_w(input int aw, input int dw);
    return dw + aw;
  endfunction
endpackage

// File: rtl/my_cpu_fetch_if.sv
// my_cpu_fetch_if: imem, redirect and instruction handshake signals of the fetch stage
interface my_cpu_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              fetch_en;
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  modport master (
    input  fetch_en, imem_rdata, redirect_valid, redirect_pc, inst_ready,
    output imem_rd, imem_addr, inst_valid, inst_data, inst_pc
  );
  modport slave (
    output fetch_en, imem_rdata, redirect_valid, redirect_pc, inst_ready,
    input  imem_rd, imem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/my_cpu_fetch_fifo.sv
// my_cpu_fetch_fifo: prefetch FIFO with flush; flush wins over push, pop alongside flush is harmless
module my_cpu_fetch_fifo import my_cpu_pkg::*; #(
  parameter int W = DEF_ENTRY_W,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  // pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // storage write; a flushed push is never stored
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= din;
  end
  assign head = mem[rptr];
endmodule

// File: rtl/my_cpu_fetch.sv
// my_cpu_fetch: PC generation, imem read issue, prefetch buffering and redirect flush
module my_cpu_fetch import my_cpu_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input logic         clk,
  input logic         RESET,
  my_cpu_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = entry_w(ADDR_W, DATA_W);
  fetch_state_e      state;
  logic [ADDR_W-1:0] pc, pc_q;
  logic              inflight, kill, issue, push, pop;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic [EW-1:0]     head;
  assign pop   = bus.inst_valid & bus.inst_ready;
  assign push  = inflight & ~kill;
  assign occ   = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = (state == RUN) && bus.fetch_en && !bus.redirect_valid && (occ < (CW+1)'(DEPTH));
  // FSM, PC and in-flight tracking; a redirect overrides the PC and forbids issue that cycle
  always_ff @(posedge clk) begin
    if (RESET) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      pc_q     <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= issue;
      kill     <= bus.redirect_valid;
      if (issue) pc_q <= pc;
      pc       <= bus.redirect_valid ? bus.redirect_pc : issue ? pc + ADDR_W'(1) : pc;
      state    <= (state == IDLE) ? (bus.fetch_en ? RUN : IDLE)
                : (!bus.fetch_en && (!inflight || bus.redirect_valid)) ? IDLE : RUN;
    end
  end
  my_cpu_fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   ({bus.imem_rdata, pc_q}),
    .head  (head),
    .count (count)
  );
  assign bus.imem_rd    = issue;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = bus.inst_valid ? head[EW-1:ADDR_W] : '0;
  assign bus.inst_pc    = bus.inst_valid ? head[ADDR_W-1:0] : '0;
endmodule

// File: tb/tb_my_cpu_fetch.sv
// tb_my_cpu_fetch: directed vector table plus hand sequences for redirect, wrap and reset corners
module tb_my_cpu_fetch;
  logic clk = 1'b0;
  logic RESET = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  my_cpu_fetch_if #(.ADDR_W(8), .DATA_W(16)) bus ();
  my_cpu_fetch #(.ADDR_W(8), .DATA_W(16), .DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus.master)
  );
  // imem model: word at address a holds 16'h1001 + a, one-cycle read latency
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_rdata <= 16'h1001 + 16'(bus.imem_addr);
  end
  // a push into a full FIFO without a simultaneous pop would lose a word
  always @(negedge clk) begin
    if (!RESET && dut.push && !dut.pop && 32'(dut.count) == 2) begin
      errors++;
      $display("FAIL push_full: push into full FIFO at time %0t", $time);
    end
  end
  typedef struct packed {
    logic        pre_rst;
    logic        fe;
    logic        rdy;
    logic        rd;
    logic [7:0]  addr;
    logic        v;
    logic [15:0] d;
    logic [7:0]  pc;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic pr, fe, rdy, rd, input logic [7:0] addr,
                              input logic v, input logic [15:0] d, input logic [7:0] pc);
    return '{pre_rst: pr, fe: fe, rdy: rdy, rd: rd, addr: addr, v: v, d: d, pc: pc};
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic rd, input logic [7:0] addr,
                         input logic v, input logic [15:0] d, input logic [7:0] pc);
    chk({tag, ".imem_rd"}, 32'(bus.imem_rd), 32'(rd));
    chk({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'(addr));
    chk({tag, ".inst_valid"}, 32'(bus.inst_valid), 32'(v));
    chk({tag, ".inst_data"}, 32'(bus.inst_data), 32'(d));
    chk({tag, ".inst_pc"}, 32'(bus.inst_pc), 32'(pc));
  endtask
  task automatic cyc(input logic rst, fe, rdy, rv, input logic [7:0] rpc);
    @(negedge clk);
    RESET = rst;
    bus.fetch_en = fe;
    bus.inst_ready = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    #1;
  endtask
  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_out("reset", 1'b0, 8'h00, 1'b0, 16'h0, 8'h00);
  endtask
  initial begin
    bus.fetch_en = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    // streaming: one word per cycle from the second cycle after the first read
    tbl.push_back(mk(1, 1, 1, 0, 8'h00, 0, 16'h0000, 8'h00));
    tbl.push_back(mk(0, 1, 1, 1, 8'h00, 0, 16'h0000, 8'h00));
    tbl.push_back(mk(0, 1, 1, 1, 8'h01, 0, 16'h0000, 8'h00));
    tbl.push_back(mk(0, 1, 1, 1, 8'h02, 1, 16'h1001, 8'h00));
    tbl.push_back(mk(0, 1, 1, 1, 8'h03, 1, 16'h1002, 8'h01));
    tbl.push_back(mk(0, 1, 1, 1, 8'h04, 1, 16'h1003, 8'h02));
    tbl.push_back(mk(0, 1, 1, 1, 8'h05, 1, 16'h1004, 8'h03));
    // back-pressure: two reads only, head held, then drain without loss; then fetch_en drop
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 0, 16'h0000, 8'h00));
    tbl.push_back(mk(0, 1, 0, 1, 8'h00, 0, 16'h0000, 8'h00));
    tbl.push_back(mk(0, 1, 0, 1, 8'h01, 0, 16'h0000, 8'h00));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 0, 0, 8'h02, 1, 16'h1001, 8'h00));
    tbl.push_back(mk(0, 1, 1, 1, 8'h02, 1, 16'h1001, 8'h00));
    tbl.push_back(mk(0, 1, 1, 1, 8'h03, 1, 16'h1002, 8'h01));
    tbl.push_back(mk(0, 1, 1, 1, 8'h04, 1, 16'h1003, 8'h02));
    tbl.push_back(mk(0, 1, 1, 1, 8'h05, 1, 16'h1004, 8'h03));
    tbl.push_back(mk(0, 0, 1, 0, 8'h06, 1, 16'h1005, 8'h04));
    tbl.push_back(mk(0, 0, 1, 0, 8'h06, 1, 16'h1006, 8'h05));
    tbl.push_back(mk(0, 0, 1, 0, 8'h06, 0, 16'h0000, 8'h00));
    tbl.push_back(mk(0, 1, 1, 0, 8'h06, 0, 16'h0000, 8'h00));
    tbl.push_back(mk(0, 1, 1, 1, 8'h06, 0, 16'h0000, 8'h00));
    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset();
      cyc(1'b0, tbl[i].fe, tbl[i].rdy, 1'b0, 8'h00);
      chk_out($sformatf("vec%0d", i), tbl[i].rd, tbl[i].addr, tbl[i].v, tbl[i].d, tbl[i].pc);
    end
    // redirect with one word buffered and one in flight: stale words never appear
    do_reset();
    cyc(0, 1, 0, 0, 8'h00); chk_out("rd_c0", 0, 8'h00, 0, 16'h0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00); chk_out("rd_c1", 1, 8'h00, 0, 16'h0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00); chk_out("rd_c2", 1, 8'h01, 0, 16'h0, 8'h00);
    cyc(0, 1, 0, 1, 8'h40); chk_out("rd_n", 0, 8'h02, 1, 16'h1001, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("rd_n1", 1, 8'h40, 0, 16'h0, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("rd_n2", 1, 8'h41, 0, 16'h0, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("rd_n3", 1, 8'h42, 1, 16'h1041, 8'h40);
    cyc(0, 1, 1, 0, 8'h00); chk_out("rd_n4", 1, 8'h43, 1, 16'h1042, 8'h41);
    // redirect together with a pop on a full FIFO: head consumed once, then flush
    do_reset();
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00); chk_out("rp_fill", 0, 8'h02, 1, 16'h1001, 8'h00);
    cyc(0, 1, 1, 1, 8'h10); chk_out("rp_n", 0, 8'h02, 1, 16'h1001, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("rp_n1", 1, 8'h10, 0, 16'h0, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("rp_n2", 1, 8'h11, 0, 16'h0, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("rp_n3", 1, 8'h12, 1, 16'h1011, 8'h10);
    // PC wrap from 8'hFF to 8'h00
    do_reset();
    cyc(0, 1, 1, 1, 8'hFF); chk_out("wr_c0", 0, 8'h00, 0, 16'h0, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("wr_c1", 1, 8'hFF, 0, 16'h0, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("wr_c2", 1, 8'h00, 0, 16'h0, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("wr_c3", 1, 8'h01, 1, 16'h1100, 8'hFF);
    cyc(0, 1, 1, 0, 8'h00); chk_out("wr_c4", 1, 8'h02, 1, 16'h1001, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("wr_c5", 1, 8'h03, 1, 16'h1002, 8'h01);
    // reset pulse with a buffered word and a return pending: all state discarded
    do_reset();
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(1, 1, 0, 0, 8'h00); chk_out("rs_pre", 0, 8'h02, 1, 16'h1001, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("rs_c0", 0, 8'h00, 0, 16'h0, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("rs_c1", 1, 8'h00, 0, 16'h0, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("rs_c2", 1, 8'h01, 0, 16'h0, 8'h00);
    cyc(0, 1, 1, 0, 8'h00); chk_out("rs_c3", 1, 8'h02, 1, 16'h1001, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
